// File: rtl/matrix_mixer_pkg.sv
// Shared constants, FSM states and the output saturator for matrix_mixer.
package mixer_pkg;

  localparam int N_CH    = 4;
  localparam int N_COEFF = 16;
  localparam int W_MAX   = 32;
  localparam int X_W     = 2 * W_MAX + 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  // floor(x / 2^(w-1)) clamped to a w-bit signed range; supports w <= W_MAX
  function automatic logic signed [W_MAX-1:0] sat(
    input logic signed [X_W-1:0] x,
    input int                    w
  );
    logic signed [X_W-1:0] s;
    logic signed [X_W-1:0] hi;
    logic signed [X_W-1:0] lo;
    s  = x >>> (w - 1);
    hi = (X_W'(1) <<< (w - 1)) - X_W'(1);
    lo = -(X_W'(1) <<< (w - 1));
    if (s > hi)      sat = hi[W_MAX-1:0];
    else if (s < lo) sat = lo[W_MAX-1:0];
    else             sat = s[W_MAX-1:0];
  endfunction

endpackage

// File: rtl/matrix_mixer.sv
// 4x4 time-multiplexed gain matrix: one multiplier walks all 16 products
// per frame, outputs update together when the last row is saturated.
module matrix_mixer
  import mixer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic              clk_256fs,
  input  logic              rst,
  input  logic              clk_fs,
  input  logic [W-1:0]      in0,
  input  logic [W-1:0]      in1,
  input  logic [W-1:0]      in2,
  input  logic [W-1:0]      in3,
  input  logic [16*W-1:0]   coeff,
  output logic [W-1:0]      out0,
  output logic [W-1:0]      out1,
  output logic [W-1:0]      out2,
  output logic [W-1:0]      out3,
  output logic              busy
);

  localparam int AW = 2 * W + 2;

  state_t state;
  state_t state_n;

  logic                fs_r;
  logic                start;
  logic [3:0]          k;
  logic signed [AW-1:0] acc;
  logic [W-1:0]        snap_in [N_CH];
  logic [16*W-1:0]     snap_c;
  logic [W-1:0]        shadow [N_CH];

  logic [1:0]            i;
  logic [1:0]            j;
  logic signed [W-1:0]   a_sel;
  logic signed [W-1:0]   c_sel;
  logic signed [2*W-1:0] p;
  logic signed [AW-1:0]  sum;

  assign start = clk_fs & ~fs_r & (state == IDLE);

  always_ff @(posedge clk_256fs) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = MAC;
      MAC: begin
        busy = 1'b1;
        if (k == 4'd15) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // k = {output row, input column}; coefficients are laid out in k order
  always_comb begin
    i     = k[1:0];
    j     = k[3:2];
    a_sel = $signed(snap_in[i]);
    c_sel = $signed(snap_c[k*W +: W]);
    p     = (2*W)'(a_sel) * (2*W)'(c_sel);
    sum   = acc + AW'(p);
  end

  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      fs_r   <= 1'b1;
      k      <= '0;
      acc    <= '0;
      snap_c <= '0;
      out0   <= '0;
      out1   <= '0;
      out2   <= '0;
      out3   <= '0;
      for (int n = 0; n < N_CH; n++) begin
        snap_in[n] <= '0;
        shadow[n]  <= '0;
      end
    end else begin
      fs_r <= clk_fs;
      unique case (state)
        IDLE: begin
          if (start) begin
            snap_in[0] <= in0;
            snap_in[1] <= in1;
            snap_in[2] <= in2;
            snap_in[3] <= in3;
            snap_c     <= coeff;
            k          <= '0;
            acc        <= '0;
          end
        end
        MAC: begin
          k <= k + 4'd1;
          if (i == 2'd3) begin
            shadow[j] <= W'(sat(X_W'(sum), W));
            acc       <= '0;
          end else begin
            acc <= sum;
          end
        end
        DONE: begin
          out0 <= shadow[0];
          out1 <= shadow[1];
          out2 <= shadow[2];
          out3 <= shadow[3];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mixer.sv
// Frame-level checks of matrix_mixer against an arithmetic mixing model.
module tb_matrix_mixer;

  logic         clk;
  logic         rst;
  logic         clk_fs;
  logic [15:0]  in0, in1, in2, in3;
  logic [255:0] coeff;
  logic [15:0]  out0, out1, out2, out3;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] prev;

  typedef struct {
    string        name;
    logic [63:0]  ins;
    logic [255:0] cf;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs[5];

  matrix_mixer #(.W(16)) dut (
    .clk_256fs(clk),
    .rst(rst),
    .clk_fs(clk_fs),
    .in0(in0),
    .in1(in1),
    .in2(in2),
    .in3(in3),
    .coeff(coeff),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(logic [63:0] ins, logic [255:0] cf);
    logic [63:0] r;
    longint s;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int n = 0; n < 4; n++)
        s += longint'($signed(ins[n*16 +: 16])) *
             longint'($signed(cf[(4*j+n)*16 +: 16]));
      s = s >>> 15;
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      r[j*16 +: 16] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [255:0] fill(logic [15:0] c);
    logic [255:0] r;
    for (int n = 0; n < 16; n++) r[n*16 +: 16] = c;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] outs();
    return {out3, out2, out1, out0};
  endfunction

  task automatic drive(logic [63:0] ins, logic [255:0] cf);
    {in3, in2, in1, in0} = ins;
    coeff = cf;
  endtask

  // chg >= 0: swap in (ins2, cf2) after that many MAC edges
  task automatic frame(string name, logic [63:0] ins, logic [255:0] cf,
                       logic [63:0] exp, int chg,
                       logic [63:0] ins2, logic [255:0] cf2);
    @(negedge clk);
    drive(ins, cf);
    clk_fs = 1;
    @(posedge clk);
    @(negedge clk);
    check({name, " busy_e0"}, {63'd0, busy}, 64'd1);
    for (int e = 1; e <= 16; e++) begin
      @(posedge clk);
      if (e == chg) begin
        @(negedge clk);
        drive(ins2, cf2);
      end
    end
    @(negedge clk);
    check({name, " hold_e16"}, outs(), prev);
    check({name, " busy_e16"}, {63'd0, busy}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    check({name, " out_e17"}, outs(), exp);
    check({name, " idle_e17"}, {63'd0, busy}, 64'd0);
    clk_fs = 0;
    prev = exp;
  endtask

  logic [63:0]  ra, rb;
  logic [255:0] ca, cb;

  initial begin
    vecs[0].name = "identity";
    vecs[0].ins  = {16'sd32767, 16'sd0, -16'sd1000, 16'sd1000};
    vecs[0].cf   = '0;
    for (int n = 0; n < 4; n++) vecs[0].cf[(5*n)*16 +: 16] = 16'h7FFF;
    vecs[0].exp  = {16'sd32766, 16'sd0, -16'sd1000, 16'sd999};
    vecs[1].name = "half_sum";
    vecs[1].ins  = {16'd0, 16'd0, 16'd16384, 16'd16384};
    vecs[1].cf   = fill(16'h4000);
    vecs[1].exp  = {4{16'd16384}};
    vecs[2].name = "sat_pos";
    vecs[2].ins  = {4{16'h7FFF}};
    vecs[2].cf   = fill(16'h7FFF);
    vecs[2].exp  = {4{16'h7FFF}};
    vecs[3].name = "sat_negneg";
    vecs[3].ins  = {4{16'h8000}};
    vecs[3].cf   = fill(16'h8000);
    vecs[3].exp  = {4{16'h7FFF}};
    vecs[4].name = "sat_neg";
    vecs[4].ins  = {4{16'h8000}};
    vecs[4].cf   = fill(16'h7FFF);
    vecs[4].exp  = {4{16'h8000}};

    rst = 1;
    clk_fs = 1;
    drive('0, '0);
    prev = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    rst = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("no_start_high", {63'd0, busy}, 64'd0);
    clk_fs = 0;

    for (int v = 0; v < 5; v++)
      frame(vecs[v].name, vecs[v].ins, vecs[v].cf, vecs[v].exp, -1, '0, '0);

    ra = {16'd300, -16'sd7000, 16'd12345, 16'd20000};
    ca = fill(16'h2000);
    rb = {ra[63:16], 16'h8000};
    cb = fill(16'hC000);
    frame("snap_a", ra, ca, model(ra, ca), 5, rb, cb);
    frame("snap_b", rb, cb, model(rb, cb), -1, '0, '0);

    @(negedge clk);
    drive(ra, ca);
    clk_fs = 1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    clk_fs = 0;
    check("midrst_outs", outs(), 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    prev = '0;
    frame("after_rst", ra, ca, model(ra, ca), -1, '0, '0);

    for (int t = 0; t < 20; t++) begin
      ra = {$urandom, $urandom};
      for (int n = 0; n < 8; n++) ca[n*32 +: 32] = $urandom;
      if (t % 5 == 0) ca[15:0] = 16'h8000;
      frame("random", ra, ca, model(ra, ca), -1, '0, '0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
